b_kp_entry: RTL and testbench
=============================

B_KP_ENTRY -- requirements
Module: b_kp_entry

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand width in bits, range 4..16.
REQ-002 Parameter SCAN_DIV, default 4: clock cycles each keypad column is driven during scanning, minimum 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 3: consecutive stable synchronised samples needed to accept a press or a release, minimum 1.
REQ-004 i_sys_clock  input  1: system clock; all state changes on its rising edge.
REQ-005 i_sys_reset  input  1: asynchronous, active-low reset.
REQ-006 i_b_kp_row  input  4: keypad rows, active-low, asynchronous to the clock.
REQ-007 i_b_kp_mode  input  1: radix select, 0 = hex (radix 16), 1 = decimal (radix 10); sampled at each key accept.
REQ-008 i_b_kp_clear  input  1: single-cycle pulse that zeroes the operand and flags.
REQ-009 i_b_kp_op_valid_key_pressed  input  1: single-cycle pulse; the next accepted digit starts a new operand.
REQ-010 o_b_kp_column  output  4: column drive, active-low, exactly one bit low at all times.
REQ-011 o_b_kp_keycode  output  DATA_WIDTH: accumulated operand.
REQ-012 o_b_kp_overflow_flag  output  1: sticky flag, set when a digit would exceed the operand range.
REQ-013 o_b_kp_new_input  output  1: one-cycle pulse in the cycle o_b_kp_keycode takes a new value from a digit.
REQ-014 o_b_kp_invalid  output  1: one-cycle pulse when a key is rejected in decimal mode.
REQ-015 o_b_kp_digit  output  4: code of the last accepted key.

Function
REQ-016 Rows pass through a 2-flop synchroniser; every row decision below uses the synchronised value.
REQ-017 Key code: column c (o_b_kp_column[c]=0) with row r low gives digit = 4*r + c.
REQ-018 FSM states:
- SCAN: column pointer advances (modulo 4) every SCAN_DIV cycles while the synchronised row equals 4'b1111. Any row bit low latches the row pattern, freezes the pointer and enters DEBOUNCE.
- DEBOUNCE: row equal to the latched pattern for DEBOUNCE_CYCLES consecutive cycles accepts the key and enters RELEASE. A different row pattern returns to SCAN with no accept.
- RELEASE: row equal to 4'b1111 for DEBOUNCE_CYCLES consecutive cycles returns to SCAN, with the pointer advanced by one. A row reading low restarts the count.
REQ-019 If more than one row bit is low at latch time, go straight to RELEASE with no accept, no pulse and no state change.
REQ-020 Accept in decimal mode with digit > 9: o_b_kp_invalid pulses for one cycle; operand, flags and o_b_kp_digit are unchanged.
REQ-021 Accept while overflow_flag = 1: ignored, except that o_b_kp_digit updates.
REQ-022 Otherwise candidate = keycode*radix + digit, computed at DATA_WIDTH+4 bits:
- candidate <= 2^DATA_WIDTH-1: keycode = candidate, and o_b_kp_new_input pulses.
- candidate > 2^DATA_WIDTH-1: overflow_flag = 1, keycode holds, and there is no new_input pulse.
REQ-023 Fresh mode: i_b_kp_op_valid_key_pressed sets an internal fresh bit. The next valid accept loads keycode = digit, clears overflow_flag, pulses new_input and clears fresh. A digit rejected under REQ-020 leaves fresh set.
REQ-024 All outputs are registered. Operand and flags update in the cycle after the DEBOUNCE_CYCLES-th stable sample. Press-to-update latency is 2 (synchroniser) + DEBOUNCE_CYCLES + 1 cycles.
REQ-025 i_b_kp_clear: keycode = 0, overflow_flag = 0, fresh = 0 on the next edge. The scan FSM is not affected.
REQ-026 Clear and accept in the same cycle: clear wins and the digit is discarded; o_b_kp_digit still updates.
REQ-027 Clear and op in the same cycle: clear wins and fresh = 0.
REQ-028 Op and accept in the same cycle: the digit starts the new operand, as in REQ-023.
REQ-029 A mode change between digits takes effect at the next accept; keycode is not reinterpreted.

Reset
REQ-030 While i_sys_reset = 0: o_b_kp_column = 4'b1110, keycode = 0, overflow_flag = 0, new_input = 0, invalid = 0, digit = 0. The FSM goes to SCAN, and the pointer, counters, fresh bit and synchroniser are cleared (synchroniser to 4'b1111).
REQ-031 Reset asserted in DEBOUNCE or RELEASE aborts the press: no accept and no pulse. Scanning restarts at column 0 after release.

Verification
REQ-032 Hex mode, press 0xF then 0x5 (each held past debounce, then released): keycode 0x0F then 0xF5, two new_input pulses, overflow 0.
REQ-033 Hex mode, F, 5, 9:
- the third accept sets overflow = 1 and keycode stays 0xF5;
- after that, a clear pulse gives keycode 0x00 and overflow 0.
REQ-034 Decimal mode:
- keys 2, 5, 5 give keycode 0xFF;
- clear, then 2, 5, 6: the last accept sets overflow and keycode stays 0x19;
- key 0xA pulses invalid with the value unchanged.
REQ-035 Bounce: row low for DEBOUNCE_CYCLES-1 synchronised cycles, then high, gives no new_input and no invalid. Two rows low together gives no accept.
REQ-036 keycode 0xF5, then an op pulse, then key 9: keycode 0x09 and a single new_input pulse. Op and clear in the same cycle, then key 3: keycode 0x03 via normal accumulate from 0.
REQ-037 Reset pulled low mid-DEBOUNCE: all outputs go to their REQ-030 values immediately, column = 4'b1110, and the held key is not accepted.

Source files
------------

// File: rtl/b_kp_entry.sv
// 4x4 keypad scanner with debounce and radix-10/16 operand accumulation.
// A scan FSM finds and debounces one key; the operand path folds accepted digits into a sticky-overflow operand.
module b_kp_entry #(
    parameter int DATA_WIDTH      = 8,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                  i_sys_clock,
    input  logic                  i_sys_reset,
    input  logic [3:0]            i_b_kp_row,
    input  logic                  i_b_kp_mode,
    input  logic                  i_b_kp_clear,
    input  logic                  i_b_kp_op_valid_key_pressed,
    output logic [3:0]            o_b_kp_column,
    output logic [DATA_WIDTH-1:0] o_b_kp_keycode,
    output logic                  o_b_kp_overflow_flag,
    output logic                  o_b_kp_new_input,
    output logic                  o_b_kp_invalid,
    output logic [3:0]            o_b_kp_digit
);

    localparam int DIV_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CAND_W = DATA_WIDTH + 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    // Index of the highest low bit of an active-low one-hot pattern.
    function automatic logic [1:0] f_low_index(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[3]) begin
            idx = 2'd3;
        end else if (!v[2]) begin
            idx = 2'd2;
        end else if (!v[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    function automatic logic f_multi_low(input logic [3:0] v);
        logic [2:0] n;
        n = 3'(~v[0]) + 3'(~v[1]) + 3'(~v[2]) + 3'(~v[3]);
        return n > 3'd1;
    endfunction

    logic [3:0]            r_sync1;
    logic [3:0]            r_sync2;
    state_t                r_state;
    logic [3:0]            r_column;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [DEB_W-1:0]      r_deb_cnt;
    logic [3:0]            r_row_latch;
    logic                  r_fresh;
    logic [DATA_WIDTH-1:0] r_keycode;
    logic                  r_overflow;
    logic                  r_new_input;
    logic                  r_invalid;
    logic [3:0]            r_digit;

    logic [3:0]        w_row;
    logic              w_idle;
    logic              w_match;
    logic              w_last;
    logic              w_accept;
    logic [3:0]        w_key;
    logic [4:0]        w_radix;
    logic              w_reject;
    logic              w_valid;
    logic              w_fresh_now;
    logic [CAND_W-1:0] w_candidate;
    logic              w_fits;
    logic [3:0]        w_col_next;

    assign w_row       = r_sync2;
    assign w_idle      = (w_row == 4'hF);
    assign w_match     = (w_row == r_row_latch);
    assign w_last      = (r_deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign w_accept    = (r_state == ST_DEBOUNCE) && w_match && w_last;
    assign w_key       = {f_low_index(r_row_latch), f_low_index(r_column)};
    assign w_radix     = i_b_kp_mode ? 5'd10 : 5'd16;
    assign w_reject    = i_b_kp_mode && (w_key > 4'd9);
    assign w_valid     = w_accept && !w_reject;
    assign w_fresh_now = r_fresh || i_b_kp_op_valid_key_pressed;
    // Widened by 4 bits so keycode*16+15 can never wrap before the range test.
    assign w_candidate = {4'b0000, r_keycode} * CAND_W'(w_radix) + CAND_W'(w_key);
    assign w_fits      = (w_candidate <= {4'b0000, {DATA_WIDTH{1'b1}}});
    assign w_col_next  = {r_column[2:0], r_column[3]};

    // Row synchroniser and scan / debounce / release state machine.
    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) begin
            r_sync1     <= 4'hF;
            r_sync2     <= 4'hF;
            r_state     <= ST_SCAN;
            r_column    <= 4'b1110;
            r_div_cnt   <= '0;
            r_deb_cnt   <= '0;
            r_row_latch <= 4'hF;
        end else begin
            r_sync1 <= i_b_kp_row;
            r_sync2 <= r_sync1;
            case (r_state)
                ST_SCAN: begin
                    if (w_idle) begin
                        if (r_div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                            r_div_cnt <= '0;
                            r_column  <= w_col_next;
                        end else begin
                            r_div_cnt <= r_div_cnt + DIV_W'(1);
                        end
                    end else begin
                        r_row_latch <= w_row;
                        r_deb_cnt   <= '0;
                        r_div_cnt   <= '0;
                        r_state     <= f_multi_low(w_row) ? ST_RELEASE : ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_match) begin
                        r_state <= ST_SCAN;
                    end else if (w_last) begin
                        r_deb_cnt <= '0;
                        r_state   <= ST_RELEASE;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!w_idle) begin
                        r_deb_cnt <= '0;
                    end else if (w_last) begin
                        r_deb_cnt <= '0;
                        r_div_cnt <= '0;
                        r_column  <= w_col_next;
                        r_state   <= ST_SCAN;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    // Operand accumulation, flags and output pulses; clear outranks accept and op.
    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) begin
            r_fresh     <= 1'b0;
            r_keycode   <= '0;
            r_overflow  <= 1'b0;
            r_new_input <= 1'b0;
            r_invalid   <= 1'b0;
            r_digit     <= 4'h0;
        end else begin
            r_new_input <= 1'b0;
            r_invalid   <= w_accept && w_reject;
            if (w_valid) begin
                r_digit <= w_key;
            end
            if (i_b_kp_clear) begin
                r_keycode  <= '0;
                r_overflow <= 1'b0;
                r_fresh    <= 1'b0;
            end else if (w_valid) begin
                if (w_fresh_now) begin
                    r_keycode   <= DATA_WIDTH'(w_key);
                    r_overflow  <= 1'b0;
                    r_fresh     <= 1'b0;
                    r_new_input <= 1'b1;
                end else if (!r_overflow) begin
                    if (w_fits) begin
                        r_keycode   <= w_candidate[DATA_WIDTH-1:0];
                        r_new_input <= 1'b1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end
            end else if (i_b_kp_op_valid_key_pressed) begin
                r_fresh <= 1'b1;
            end
        end
    end

    assign o_b_kp_column        = r_column;
    assign o_b_kp_keycode       = r_keycode;
    assign o_b_kp_overflow_flag = r_overflow;
    assign o_b_kp_new_input     = r_new_input;
    assign o_b_kp_invalid       = r_invalid;
    assign o_b_kp_digit         = r_digit;

endmodule

// File: tb/tb_b_kp_entry.sv
// Bench for b_kp_entry: a keypad model drives rows from the column output,
// and a behavioural operand model predicts keycode, flags and pulse counts.
module tb_b_kp_entry;

    localparam int W  = 8;
    localparam int SD = 4;
    localparam int DC = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   kp_row;
    logic         mode;
    logic         clr;
    logic         op;
    logic [3:0]   col;
    logic [W-1:0] kc;
    logic         ovf;
    logic         newi;
    logic         inv;
    logic [3:0]   dig;

    int checks = 0;
    int errors = 0;
    int new_cnt = 0;
    int inv_cnt = 0;

    int exp_kc = 0;
    int exp_dig = 0;
    int exp_new = 0;
    int exp_inv = 0;
    bit exp_ovf = 1'b0;
    bit exp_fresh = 1'b0;

    logic       ka_en = 1'b0;
    logic       kb_en = 1'b0;
    logic [3:0] ka_d = 4'h0;
    logic [3:0] kb_d = 4'h0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'hF;

    b_kp_entry #(.DATA_WIDTH(W), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
        .i_sys_clock                 (clk),
        .i_sys_reset                 (rst_n),
        .i_b_kp_row                  (kp_row),
        .i_b_kp_mode                 (mode),
        .i_b_kp_clear                (clr),
        .i_b_kp_op_valid_key_pressed (op),
        .o_b_kp_column               (col),
        .o_b_kp_keycode              (kc),
        .o_b_kp_overflow_flag        (ovf),
        .o_b_kp_new_input            (newi),
        .o_b_kp_invalid              (inv),
        .o_b_kp_digit                (dig)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        kp_row = 4'hF;
        if (ka_en && col[ka_d[1:0]] == 1'b0) kp_row[ka_d[3:2]] = 1'b0;
        if (kb_en && col[kb_d[1:0]] == 1'b0) kp_row[kb_d[3:2]] = 1'b0;
        if (force_en) kp_row = force_val;
    end

    always @(negedge clk) begin
        if (newi === 1'b1) new_cnt++;
        if (inv === 1'b1) inv_cnt++;
    end

    task automatic model_key(input int d, input bit dec);
        int radix;
        int cand;
        radix = dec ? 10 : 16;
        if (dec && d > 9) begin
            exp_inv++;
            return;
        end
        exp_dig = d;
        if (exp_fresh) begin
            exp_kc = d; exp_ovf = 1'b0; exp_fresh = 1'b0; exp_new++;
        end else if (!exp_ovf) begin
            cand = exp_kc * radix + d;
            if (cand > (1 << W) - 1) exp_ovf = 1'b1;
            else begin exp_kc = cand; exp_new++; end
        end
    endtask

    task automatic press(input logic [3:0] d, input bit dec);
        @(negedge clk);
        mode = dec; ka_d = d; ka_en = 1'b1;
        repeat (40) @(negedge clk);
        ka_en = 1'b0;
        repeat (20) @(negedge clk);
        model_key(int'(d), dec);
    endtask

    task automatic pulse(input logic c, input logic o);
        @(negedge clk);
        clr = c; op = o;
        @(negedge clk);
        clr = 1'b0; op = 1'b0;
        if (c) begin exp_kc = 0; exp_ovf = 1'b0; exp_fresh = 1'b0; end
        else if (o) exp_fresh = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] seen;
        int bad;
        rst_n = 1'b0; mode = 1'b0; clr = 1'b0; op = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", col); end
        checks++; if (kc !== 8'h00) begin errors++; $display("FAIL reset_kc got %h want 00", kc); end
        checks++; if ({ovf, newi, inv, dig} !== 7'b0) begin errors++; $display("FAIL reset_flags got %b want 0", {ovf, newi, inv, dig}); end
        rst_n = 1'b1;
        seen = 4'h0; bad = 0;
        for (int i = 0; i < 4 * SD + 4; i++) begin
            @(negedge clk);
            seen |= ~col;
            if ($countones(~col) != 1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL scan_onehot got %0d bad samples want 0", bad); end
        checks++; if (seen !== 4'hF) begin errors++; $display("FAIL scan_rotate got %b want 1111", seen); end
    endtask

    task automatic test_hex_basic();
        int n0;
        n0 = new_cnt;
        press(4'hF, 1'b0);
        checks++; if (kc !== 8'h0F) begin errors++; $display("FAIL hex_first got %h want 0f", kc); end
        press(4'h5, 1'b0);
        checks++; if (kc !== 8'hF5) begin errors++; $display("FAIL hex_second got %h want f5", kc); end
        checks++; if (new_cnt - n0 != 2) begin errors++; $display("FAIL hex_pulses got %0d want 2", new_cnt - n0); end
        checks++; if (ovf !== 1'b0 || dig !== 4'h5) begin errors++; $display("FAIL hex_flags got ovf %b dig %h want 0 5", ovf, dig); end
    endtask

    task automatic test_hex_overflow();
        press(4'h9, 1'b0);
        checks++; if (kc !== 8'hF5 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %h/%b want f5/1", kc, ovf); end
        press(4'h3, 1'b0);
        checks++; if (kc !== 8'hF5 || dig !== 4'h3) begin errors++; $display("FAIL ovf_ignore got %h dig %h want f5 3", kc, dig); end
        pulse(1'b1, 1'b0);
        checks++; if (kc !== 8'h00 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %h/%b want 00/0", kc, ovf); end
    endtask

    task automatic test_decimal();
        int i0;
        press(4'h2, 1'b1); press(4'h5, 1'b1); press(4'h5, 1'b1);
        checks++; if (kc !== 8'hFF || ovf !== 1'b0) begin errors++; $display("FAIL dec_255 got %h/%b want ff/0", kc, ovf); end
        pulse(1'b1, 1'b0);
        press(4'h2, 1'b1); press(4'h5, 1'b1); press(4'h6, 1'b1);
        checks++; if (kc !== 8'h19 || ovf !== 1'b1) begin errors++; $display("FAIL dec_256 got %h/%b want 19/1", kc, ovf); end
        i0 = inv_cnt;
        press(4'hA, 1'b1);
        checks++; if (inv_cnt - i0 != 1) begin errors++; $display("FAIL dec_invalid got %0d pulses want 1", inv_cnt - i0); end
        checks++; if (kc !== 8'h19 || dig !== 4'h6) begin errors++; $display("FAIL dec_inv_hold got %h dig %h want 19 6", kc, dig); end
        pulse(1'b1, 1'b0);
    endtask

    task automatic test_latency();
        logic [3:0] prev;
        bit found;
        int lat;
        mode = 1'b0; found = 1'b0; prev = col;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = col;
        end
        checks++; if (!found) begin errors++; $display("FAIL lat_align got no column-0 window want one"); end
        force_val = 4'b1011; force_en = 1'b1; lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (newi === 1'b1) lat = i;
        end
        model_key(8, 1'b0);
        checks++; if (lat != 2 + DC + 1) begin errors++; $display("FAIL latency got %0d want %0d", lat, 2 + DC + 1); end
        checks++; if (kc !== exp_kc[W-1:0] || dig !== 4'h8) begin errors++; $display("FAIL lat_value got %h dig %h want %h 8", kc, dig, exp_kc[W-1:0]); end
        force_val = 4'hF;
        repeat (20) @(negedge clk);
        force_en = 1'b0;
    endtask

    task automatic test_bounce();
        int n0, i0;
        n0 = new_cnt; i0 = inv_cnt;
        force_val = 4'b1110; force_en = 1'b1;
        repeat (DC - 1) @(negedge clk);
        force_val = 4'hF;
        repeat (20) @(negedge clk);
        force_en = 1'b0;
        checks++; if (new_cnt != n0 || inv_cnt != i0) begin errors++; $display("FAIL bounce got %0d/%0d pulses want 0/0", new_cnt - n0, inv_cnt - i0); end
        checks++; if (kc !== exp_kc[W-1:0]) begin errors++; $display("FAIL bounce_kc got %h want %h", kc, exp_kc[W-1:0]); end
    endtask

    task automatic test_multi_row();
        int n0;
        n0 = new_cnt;
        @(negedge clk);
        mode = 1'b0; ka_d = 4'h1; kb_d = 4'h5; ka_en = 1'b1; kb_en = 1'b1;
        repeat (40) @(negedge clk);
        ka_en = 1'b0; kb_en = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (new_cnt != n0) begin errors++; $display("FAIL multi_pulse got %0d want 0", new_cnt - n0); end
        checks++; if (kc !== exp_kc[W-1:0] || dig !== exp_dig[3:0]) begin errors++; $display("FAIL multi_hold got %h dig %h want %h %h", kc, dig, exp_kc[W-1:0], exp_dig[3:0]); end
    endtask

    task automatic test_op();
        int n0;
        pulse(1'b1, 1'b0);
        press(4'hF, 1'b0); press(4'h5, 1'b0);
        pulse(1'b0, 1'b1);
        n0 = new_cnt;
        press(4'h9, 1'b0);
        checks++; if (kc !== 8'h09 || new_cnt - n0 != 1) begin errors++; $display("FAIL op_fresh got %h pulses %0d want 09 1", kc, new_cnt - n0); end
        pulse(1'b1, 1'b1);
        press(4'h3, 1'b0);
        checks++; if (kc !== 8'h03) begin errors++; $display("FAIL op_clear got %h want 03", kc); end
        press(4'hF, 1'b0); press(4'h5, 1'b0); press(4'h9, 1'b0);
        pulse(1'b0, 1'b1);
        press(4'h2, 1'b0);
        checks++; if (kc !== 8'h02 || ovf !== 1'b0) begin errors++; $display("FAIL op_ovf got %h/%b want 02/0", kc, ovf); end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] d;
        bit dec;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) pulse(1'b1, 1'b0);
            else if (r == 1) pulse(1'b0, 1'b1);
            d = 4'($urandom_range(0, 15));
            dec = 1'($urandom_range(0, 1));
            press(d, dec);
            checks++; if (kc !== exp_kc[W-1:0] || ovf !== exp_ovf) begin errors++; $display("FAIL rand_kc[%0d] got %h/%b want %h/%b", i, kc, ovf, exp_kc[W-1:0], exp_ovf); end
            checks++; if (dig !== exp_dig[3:0]) begin errors++; $display("FAIL rand_dig[%0d] got %h want %h", i, dig, exp_dig[3:0]); end
            checks++; if (new_cnt != exp_new || inv_cnt != exp_inv) begin errors++; $display("FAIL rand_pulses[%0d] got %0d/%0d want %0d/%0d", i, new_cnt, inv_cnt, exp_new, exp_inv); end
            checks++; if ($countones(~col) != 1) begin errors++; $display("FAIL rand_col[%0d] got %b want one low", i, col); end
        end
    endtask

    task automatic test_reset_mid_debounce();
        int n0;
        pulse(1'b1, 1'b0);
        press(4'h7, 1'b0);
        @(negedge clk);
        force_val = 4'b0111; force_en = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (col !== 4'b1110 || kc !== 8'h00) begin errors++; $display("FAIL rstmid_col_kc got %b %h want 1110 00", col, kc); end
        checks++; if ({ovf, newi, inv, dig} !== 7'b0) begin errors++; $display("FAIL rstmid_flags got %b want 0", {ovf, newi, inv, dig}); end
        force_en = 1'b0;
        exp_kc = 0; exp_ovf = 1'b0; exp_fresh = 1'b0; exp_dig = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n0 = new_cnt;
        repeat (40) @(negedge clk);
        checks++; if (new_cnt != n0 || kc !== 8'h00) begin errors++; $display("FAIL rstmid_abort got %0d pulses kc %h want 0 00", new_cnt - n0, kc); end
    endtask

    initial begin
        test_reset();
        test_hex_basic();
        test_hex_overflow();
        test_decimal();
        test_latency();
        test_bounce();
        test_multi_row();
        test_op();
        test_random();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
